// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmitter.
package uart_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 9600;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } uart_state_e;

  // Integer-truncated clocks per bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: held at zero by clear, then ticks bit_end every CLKS_PER_BIT cycles.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Wrapping at every boundary keeps each bit exactly CLKS_PER_BIT long.
  always_ff @(posedge clk) begin
    if (!reset || clear)  cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign bit_end = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// 8-N-1 UART serializer, LSB first, registered tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_busy,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  uart_state_e state, state_nxt;
  logic        bit_end;
  logic [2:0]  bit_idx;
  logic [7:0]  shift, shift_nxt;
  logic        tx_nxt;
`ifdef UART_TX_PARITY_EN
  logic        parity;
`endif

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!tx_busy) state_nxt = START;
      START: if (bit_end)  state_nxt = DATA;
      DATA:
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP:  if (bit_end)  state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // tx is decoded from the upcoming state so the line changes on the same edge as the FSM.
  always_comb begin
    shift_nxt = shift;
    if (state == START && bit_end)     shift_nxt = data_in;
    else if (state == DATA && bit_end) shift_nxt = shift >> 1;

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nxt = parity;
`endif
      default: tx_nxt = 1'b1;
    endcase

    done = (state == STOP) && bit_end;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      shift <= shift_nxt;
      tx    <= tx_nxt;
      if (state == IDLE)                 bit_idx <= '0;
      else if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
      if (state == START && bit_end)     parity  <= ^data_in;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core at a shortened bit period (16 clocks per bit).
module tb_uart_tx_core;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int CPB      = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS    = 11;
`else
  localparam int NBITS    = 10;
`endif
  localparam int FRAME    = NBITS * CPB;
  localparam int NS       = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_busy = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       tx, done;

  int   checks = 0;
  int   failures = 0;
  int   cyc = -1000;
  logic txs [NS];
  logic dns [NS];

  uart_tx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_busy (tx_busy),
    .data_in (data_in),
    .tx      (tx),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc >= 0 && cyc < NS) begin
      txs[cyc] = tx;
      dns[cyc] = done;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // Called on a negedge; cycle 0 is the cycle after the request is sampled.
  task automatic begin_frame(input logic [7:0] d);
    for (int i = 0; i < NS; i++) begin
      txs[i] = 1'bx;
      dns[i] = 1'b0;
    end
    data_in = d;
    tx_busy = 1'b0;
    cyc     = -1;
  endtask

  function automatic logic [7:0] byte_at(input int base);
    logic [7:0] b;
    for (int n = 0; n < 8; n++) b[n] = txs[base + CPB*(n+1) + CPB/2];
    return b;
  endfunction

  function automatic int count_low(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (txs[i] !== 1'b1) c++;
    return c;
  endfunction

  function automatic int count_done(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (dns[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [8:0] bits;
    int         lows;

    // Reset and quiescent idle
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_done", done, 0);
    reset = 1'b1;
    lows  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || done !== 1'b0) lows++;
    end
    chk("idle_quiet", lows, 0);

    // Single frame, data arrives late inside the start bit, then changes after latch
    chk("pre_req_tx", tx, 1);
    begin_frame(8'h3C);
    run_to(10);
    data_in = 8'hA5;
    run_to(30);
    tx_busy = 1'b1;
    run_to(40);
    data_in = 8'h00;
    run_to(FRAME + 40);
    chk("latency_start", txs[0], 0);
    chk("start_last", txs[CPB-1], 0);
    chk("bit0_first", txs[CPB], 1);
    for (int n = 0; n < 9; n++) bits[n] = txs[n*CPB + CPB/2];
    chk("a5_bits", bits, 9'h14A);
`ifdef UART_TX_PARITY_EN
    chk("a5_parity", txs[9*CPB + CPB/2], 0);
`endif
    chk("a5_stop", txs[(NBITS-1)*CPB + CPB/2], 1);
    chk("a5_done_cnt", count_done(0, FRAME + 39), 1);
    chk("a5_done_at", dns[FRAME-1], 1);
    chk("a5_idle_after", count_low(FRAME - CPB, FRAME + 39), 0);

    // Back-to-back frames 00 then FF
    begin_frame(8'h00);
    run_to(20);
    data_in = 8'hFF;
    run_to(FRAME + 40);
    tx_busy = 1'b1;
    run_to(2*FRAME + 39);
    chk("b2b_idle_gap", txs[FRAME], 1);
    chk("b2b_start2", txs[FRAME+1], 0);
    chk("b2b_byte1", byte_at(0), 8'h00);
    chk("b2b_byte2", byte_at(FRAME+1), 8'hFF);
    chk("b2b_done_cnt", count_done(0, 2*FRAME + 39), 2);
    chk("b2b_done1", dns[FRAME-1], 1);
    chk("b2b_done2", dns[2*FRAME], 1);
    chk("b2b_idle_after", count_low(2*FRAME + 1, 2*FRAME + 39), 0);

    // Request released during data bit 4
    begin_frame(8'h5A);
    run_to(4*CPB + 5);
    tx_busy = 1'b1;
    run_to(FRAME + 100);
    chk("rel_byte", byte_at(0), 8'h5A);
    chk("rel_done_cnt", count_done(0, FRAME + 99), 1);
    chk("rel_done_at", dns[FRAME-1], 1);
    chk("rel_idle_after", count_low(FRAME, FRAME + 99), 0);

    // Reset during data bit 3 (line low there for C3)
    begin_frame(8'hC3);
    run_to(5);
    tx_busy = 1'b1;
    run_to(70);
    chk("rst_mid_pre", txs[70], 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    run_to(FRAME + 20);
    chk("rst_mid_tx", txs[71], 1);
    chk("rst_mid_done", dns[71], 0);
    chk("rst_no_done", count_done(0, FRAME + 20), 0);
    chk("rst_line_high", count_low(71, FRAME + 20), 0);

    // Fresh frame after the abort
    begin_frame(8'h81);
    run_to(5);
    tx_busy = 1'b1;
    run_to(FRAME + 10);
    chk("fresh_byte", byte_at(0), 8'h81);
    chk("fresh_done_cnt", count_done(0, FRAME + 10), 1);
    chk("fresh_done_at", dns[FRAME-1], 1);

`ifdef UART_TX_PARITY_EN
    begin_frame(8'h07);
    run_to(5);
    tx_busy = 1'b1;
    run_to(FRAME + 10);
    chk("p07_byte", byte_at(0), 8'h07);
    chk("p07_parity", txs[9*CPB + CPB/2], 1);
    chk("p07_stop", txs[10*CPB + CPB/2], 1);
    chk("p07_done_at", dns[11*CPB - 1], 1);
    chk("p07_done_cnt", count_done(0, FRAME + 10), 1);

    begin_frame(8'h03);
    run_to(5);
    tx_busy = 1'b1;
    run_to(FRAME + 10);
    chk("p03_parity", txs[9*CPB + CPB/2], 0);
    chk("p03_stop", txs[10*CPB + CPB/2], 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

8-N-1 UART serializer transmitting one byte per frame on a single-wire `tx` line, LSB first, at a fixed baud rate derived from the system clock. It sits between a byte-producing controller and the board-level serial pin. The controller holds the active-low send request `tx_busy` low to request transmission, and `done` marks frame completion.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bits/s.
- `CLKS_PER_BIT`, `CLK_FREQ/BAUD` (5208): clocks per bit, integer-truncated; localparam.
- `clk` input 1: single system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-low reset.
- `tx_busy` input 1: active-low send request. 0 means transmit; 1 means stay idle.
- `data_in` input 8: byte to send, sampled once per frame.
- `tx` output 1: serial line, idles high.
- `done` output 1: one-cycle pulse at frame end.

## Operation
- FSM states: IDLE, START, DATA, STOP, plus PARITY when configured.
- IDLE:
  - `tx`=1.
  - When `tx_busy`=0 is sampled, go to START and clear the bit counter.
- START:
  - `tx`=0 for CLKS_PER_BIT cycles.
  - On its last cycle, latch `data_in` into an 8-bit shift register. `data_in` therefore only has to be valid by the end of the start bit.
  - Then go to DATA.
- DATA:
  - Drive `shift[0]` for CLKS_PER_BIT cycles, then shift right.
  - 3-bit index counts 0..7. After bit 7, go to STOP (or PARITY when configured).
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles.
  - `done`=1 on its final cycle only, then go to IDLE.
- Back-to-back frames: if `tx_busy` is still 0 in IDLE, the next start bit begins. Each frame re-latches `data_in`.
- Ignored during a frame:
  - `tx_busy` rising mid-frame; the frame always completes.
  - `data_in` changes after the latch point.
- Baud counter:
  - Width `$clog2(CLKS_PER_BIT)`.
  - Counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. No drift accumulates across bits.
- `tx` is a registered output, so there are no glitches.

## Timing
- Reset (`reset`=0 at a clock edge):
  - Next edge: state IDLE, `tx`=1, `done`=0, counters 0, shift register 0.
  - Applies mid-frame too; the frame is aborted with the line high.
- Request to start bit: `tx` falls on the first rising edge after `tx_busy`=0 is sampled in IDLE (1-cycle latency).
- Frame length: 10×CLKS_PER_BIT = 52080 cycles, which is 1.0416 ms at defaults.
- Bit n (0 = start) occupies cycles [n×CLKS_PER_BIT, (n+1)×CLKS_PER_BIT) after the start-bit edge.
- `done`: high for exactly 1 cycle, at cycle 10×CLKS_PER_BIT−1 of the frame.
- Back-to-back spacing: IDLE lasts 1 cycle, so consecutive start bits are 10×CLKS_PER_BIT+1 cycles apart.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- When defined:
  - PARITY state inserted between DATA and STOP.
  - `tx` = even parity (XOR of the 8 latched bits) for CLKS_PER_BIT cycles.
  - Frame is 11 bits; `done` occurs at cycle 11×CLKS_PER_BIT−1.
- When undefined: 8-N-1 exactly as above; no parity logic is synthesized.

## Structure
- Package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP, PARITY.
  - Default `CLK_FREQ`/`BAUD` constants.
  - Function computing CLKS_PER_BIT.
- Sub-module `uart_baud_gen`:
  - Cleared at frame start.
  - Outputs a one-cycle `bit_end` tick every CLKS_PER_BIT cycles.
  - The FSM advances only on `bit_end`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles → `tx`=1, `done`=0. Release with `tx_busy`=1 → `tx` stays 1 indefinitely.
- Single frame with late data:
  - Stimulus: `tx_busy`=0, then `data_in`=8'hA5 set 1000 cycles later, still within the start bit.
  - Required `tx` sampled mid-bit: 0,1,0,1,0,0,1,0,1,1 (start bit, then LSB-first data, then stop bit).
  - `done` is a single pulse at cycle 52079 of the frame.
- Back-to-back:
  - Stimulus: hold `tx_busy`=0 with `data_in`=8'h00, then 8'hFF.
  - Second start bit begins 52081 cycles after the first; second frame carries 8'hFF.
- Mid-frame release:
  - Stimulus: `tx_busy`=1 during bit 4.
  - Frame completes; `done` pulses; `tx` then stays 1.
- Mid-frame reset:
  - Stimulus: `reset`=0 during DATA bit 3.
  - `tx`=1 and `done`=0 next cycle; no `done` pulse for the aborted frame. A new request starts a fresh frame.
- `UART_TX_PARITY_EN` defined, `data_in`=8'h07: parity bit = 1, stop bit follows, `done` at cycle 57287.
